// File: rtl/shift_pkg.sv
// Shared definitions for the serial left shifter: FSM state encoding and shift-mode constants.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_LSL = 1'b0;
    localparam logic MODE_ROL = 1'b1;

endpackage

// File: rtl/shift_left_serial.sv
// Serial left shifter: one bit per clock, logical or rotate, with signed-overflow tracking.
// Valid/ready handshake on both sides; one request in flight at a time.
module shift_left_serial
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int MAX_AMT = WIDTH - 1;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  data_reg,  data_next;
    logic [AMTW-1:0]   cnt_reg,   cnt_next;
    logic              mode_reg,  mode_next;
    logic              ovf_reg,   ovf_next;
    logic [AMTW-1:0]   amt_sat;

    // Amounts beyond the word width only arise for non-power-of-2 WIDTH.
    assign amt_sat = (int'(in_amt) > MAX_AMT) ? AMTW'(MAX_AMT) : in_amt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            mode_reg  <= MODE_LSL;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        ovf_next   = ovf_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_next  = in_data;
                    cnt_next   = amt_sat;
                    mode_next  = in_mode;
                    ovf_next   = 1'b0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A zero count spends one pass cycle so latency is uniformly max(amt,1).
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    data_next = {data_reg[WIDTH-2:0],
                                 (mode_reg == MODE_ROL) ? data_reg[WIDTH-1] : 1'b0};
                    if ((mode_reg == MODE_LSL) && (data_reg[WIDTH-1] != data_reg[WIDTH-2]))
                        ovf_next = 1'b1;
                    cnt_next = cnt_reg - AMTW'(1);
                    if (cnt_reg == AMTW'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_data = data_reg;
    assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_shift_left_serial.sv
// Randomized self-checking bench for shift_left_serial, 8-bit and 6-bit instances.
module tb_shift_left_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_ovf;
    logic [7:0] in_data, out_data;
    logic [2:0] in_amt;

    logic       in_valid6, in_ready6, in_mode6, out_valid6, out_ready6, out_ovf6;
    logic [5:0] in_data6, out_data6;
    logic [2:0] in_amt6;

    int n_checks = 0;
    int n_pass   = 0;

    shift_left_serial #(.WIDTH(8), .AMTW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    shift_left_serial #(.WIDTH(6), .AMTW(3)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .in_amt(in_amt6), .in_mode(in_mode6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_data(out_data6), .out_ovf(out_ovf6)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: x*2^n as a value; overflow when the top n+1 bits are not all equal.
    function automatic void ref_model(input longint unsigned d, input int amt, input bit m,
                                      input int w, output longint unsigned r, output bit o);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned top;
        int a = (amt > w - 1) ? w - 1 : amt;
        if (m) begin
            r = ((d << a) | (d >> (w - a))) & mask;
            o = 1'b0;
        end else begin
            r   = (d << a) & mask;
            top = d >> (w - 1 - a);
            o   = !((top == 0) || (top == ((64'd1 << (a + 1)) - 1)));
        end
    endfunction

    task automatic do_txn(input logic [7:0] d, input logic [2:0] a, input logic m,
                          input int hold, input logic [7:0] exp_d, input logic exp_o);
        int lat;
        logic [7:0] held;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (a == 0) ? 1 : int'(a));
        chk("out_data", out_data, exp_d);
        chk("out_ovf", out_ovf, exp_o);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'($urandom); in_amt = 3'($urandom); out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held);
            chk("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        @(negedge clk);
        out_ready = 1'b0;
        $display("txn8 data=%02h amt=%0d mode=%0d hold=%0d -> out=%02h ovf=%0d lat=%0d",
                 d, a, m, hold, held, exp_o, lat);
    endtask

    task automatic txn6(input logic [5:0] d, input logic [2:0] a, input logic m);
        longint unsigned r;
        bit o;
        int lat;
        int sat = (a > 5) ? 5 : int'(a);
        ref_model(longint'(d), int'(a), m, 6, r, o);
        @(negedge clk);
        in_valid6 = 1'b1; in_data6 = d; in_amt6 = a; in_mode6 = m;
        @(posedge clk); #1;
        in_valid6 = 1'b0;
        lat = 0;
        while (!out_valid6 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w6_latency", lat, (sat == 0) ? 1 : sat);
        chk("w6_out_data", out_data6, r);
        chk("w6_out_ovf", out_ovf6, o);
        @(posedge clk); #1;
        chk("w6_in_ready", in_ready6, 1);
        $display("txn6 data=%02h amt=%0d mode=%0d -> out=%02h ovf=%0d lat=%0d",
                 d, a, m, r, o, lat);
    endtask

    initial begin
        longint unsigned r;
        bit o;
        logic [7:0] d;
        logic [2:0] a;
        logic m;
        int nv;

        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_amt = 0; in_mode = 0; out_ready = 0;
        in_valid6 = 0; in_data6 = 0; in_amt6 = 0; in_mode6 = 0; out_ready6 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(8'hA3, 3'd2, 1'b0, 0, 8'h8C, 1'b1);
        do_txn(8'h0F, 3'd3, 1'b0, 1, 8'h78, 1'b0);
        do_txn(8'hA3, 3'd3, 1'b1, 0, 8'h1D, 1'b0);
        do_txn(8'h5A, 3'd0, 1'b0, 0, 8'h5A, 1'b0);
        do_txn(8'h5A, 3'd0, 1'b1, 0, 8'h5A, 1'b0);
        do_txn(8'h3C, 3'd1, 1'b0, 5, 8'h78, 1'b0);
        do_txn(8'h81, 3'd7, 1'b1, 0, 8'hC0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            m = 1'($urandom);
            ref_model(longint'(d), int'(a), m, 8, r, o);
            do_txn(d, a, m, $urandom_range(0, 2), 8'(r), o);
        end

        // Reset in the middle of a 7-step shift.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_data", out_data, 8'hF8);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("no_valid_after_rst", nv, 0);
        $display("reset-abort amt=7 after 3 shifts -> out_valid count after release=%0d", nv);

        txn6(6'h2B, 3'd6, 1'b0);
        txn6(6'h2B, 3'd7, 1'b1);
        txn6(6'h15, 3'd5, 1'b0);
        txn6(6'h21, 3'd2, 1'b1);
        txn6(6'h07, 3'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
